// File: rtl/arb_pkg.sv
// -----------------------------------------------------------------------------
// arb_pkg -- shared definitions for the round-robin arbiter family.
//
// Contents:
//   ARB_MAX_N    upper bound on the number of requesters (32)
//   arb_state_e  arbiter FSM states: IDLE (no owner), LOCKED (one owner)
//   onehot2bin   one-hot (up to ARB_MAX_N bits) to binary index
//
// Optional feature macro used by the arbiter top: ARB_BURST_LIMIT_EN
// -----------------------------------------------------------------------------
package arb_pkg;

    localparam int ARB_MAX_N  = 32;
    localparam int ARB_IDX_W  = $clog2(ARB_MAX_N);

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } arb_state_e;

    // OR-reduce the index of every set bit; exact for one-hot or zero input.
    function automatic logic [ARB_IDX_W-1:0] onehot2bin(input logic [ARB_MAX_N-1:0] oh);
        logic [ARB_IDX_W-1:0] idx;
        idx = {ARB_IDX_W{1'b0}};
        for (int i = 0; i < ARB_MAX_N; i++) begin
            idx = idx | (oh[i] ? ARB_IDX_W'(i) : {ARB_IDX_W{1'b0}});
        end
        return idx;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// -----------------------------------------------------------------------------
// rr_pick -- combinational round-robin pick.
//
// Returns the first set bit of req at or after index ptr+1, wrapping modulo N,
// as a one-hot vector. Uses a masked double-width priority search: the lower
// half holds only requests strictly above ptr, the upper half holds all
// requests, so the lowest set bit of the concatenation is the wrapped winner.
//
// Ports:
//   req   in  N   request vector
//   ptr   in  IW  index of the most recent owner (lowest priority)
//   pick  out N   one-hot winner, zero when req is zero
//   any   out 1   at least one request is present
// -----------------------------------------------------------------------------
module rr_pick
    import arb_pkg::*;
#(
    parameter int N  = 4,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  pick,
    output logic          any
);

    logic [N-1:0]   w_mask;
    logic [2*N-1:0] w_dbl;
    logic [2*N-1:0] w_first;
    logic           w_found;

    // Masked double-width lowest-set-bit search, folded back to N bits.
    always_comb begin
        w_mask  = {N{1'b0}};
        w_first = {(2*N){1'b0}};
        w_found = 1'b0;
        for (int i = 0; i < N; i++) begin
            w_mask[i] = (i > int'(ptr));
        end
        w_dbl = {req, req & w_mask};
        for (int j = 0; j < 2*N; j++) begin
            w_first[j] = w_dbl[j] & ~w_found;
            w_found    = w_found | w_dbl[j];
        end
        pick = w_first[N-1:0] | w_first[2*N-1:N];
        any  = |req;
    end

endmodule

// File: rtl/rr_arbiter_lock.sv
// -----------------------------------------------------------------------------
// rr_arbiter_lock -- round-robin arbiter with transaction locking.
//
// The grant stays with its owner until a release event (ack & last, the owner
// dropping req, or an optional burst-limit forced release). On release the
// arbiter re-arbitrates in the same cycle, so handover has no idle bubble.
// The pointer holds the last owner, which makes it lowest priority next time.
//
// Optional feature: define ARB_BURST_LIMIT_EN to add a beat counter that
// forces a release after MAX_BURST accepted beats. Without it MAX_BURST has
// no effect.
//
// Ports:
//   clk        in  1   clock, rising edge
//   rst        in  1   synchronous active-high reset
//   req        in  N   per-requester request level
//   ack        in  1   downstream accepted one beat from the owner
//   last       in  1   qualifies ack as the owner's final beat
//   grant      out N   registered one-hot grant, zero when idle
//   grant_idx  out IW  binary owner index, zero when idle
//   grant_vld  out 1   a grant is held
// -----------------------------------------------------------------------------
module rr_arbiter_lock
    import arb_pkg::*;
#(
    parameter int  N         = 4,
    parameter int  MAX_BURST = 16,
    localparam int IW        = (N > 1) ? $clog2(N) : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [N-1:0]  req,
    input  logic          ack,
    input  logic          last,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] grant_idx,
    output logic          grant_vld
);

    arb_state_e    r_state;
    logic [IW-1:0] r_ptr;
    logic [N-1:0]  r_grant;
    logic [IW-1:0] r_grant_idx;
    logic          r_grant_vld;

    arb_state_e    w_nxt_state;
    logic [IW-1:0] w_nxt_ptr;
    logic [N-1:0]  w_nxt_grant;
    logic [N-1:0]  w_pick;
    logic [IW-1:0] w_pick_idx;
    logic          w_any;
    logic          w_owner_req;
    logic          w_force;
    logic          w_release;
    logic          w_arb;

    rr_pick #(
        .N  (N),
        .IW (IW)
    ) u_pick (
        .req  (req),
        .ptr  (r_ptr),
        .pick (w_pick),
        .any  (w_any)
    );

    assign w_pick_idx  = IW'(onehot2bin(ARB_MAX_N'(w_pick)));
    assign w_owner_req = |(req & r_grant);

    // Ack & last and an owner abort in the same cycle collapse into one
    // release, so the pointer advances only once.
    assign w_release = (ack & last) | ~w_owner_req | w_force;

`ifdef ARB_BURST_LIMIT_EN
    localparam int CW = $clog2(MAX_BURST + 1);

    logic [CW-1:0] r_beat_cnt;

    // The ack that completes beat MAX_BURST is itself the forced release.
    assign w_force = (r_state == LOCKED) && ack && (r_beat_cnt == CW'(MAX_BURST - 1));

    // Beat counter: cleared on every arbitration, counts acks while locked.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_beat_cnt <= {CW{1'b0}};
        end else if (w_arb) begin
            r_beat_cnt <= {CW{1'b0}};
        end else if ((r_state == LOCKED) && ack) begin
            r_beat_cnt <= r_beat_cnt + CW'(1);
        end else begin
            r_beat_cnt <= r_beat_cnt;
        end
    end
`else
    // No burst limit: MAX_BURST is referenced only to keep the parameter live.
    assign w_force = (MAX_BURST > 0) ? 1'b0 : 1'b0;
`endif

    // Next-state logic: arbitrate from IDLE, or on a release while LOCKED.
    always_comb begin
        w_nxt_state = r_state;
        w_nxt_ptr   = r_ptr;
        w_nxt_grant = r_grant;
        w_arb       = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_any) begin
                    w_nxt_state = LOCKED;
                    w_nxt_grant = w_pick;
                    w_nxt_ptr   = w_pick_idx;
                    w_arb       = 1'b1;
                end else begin
                    w_nxt_state = IDLE;
                end
            end
            LOCKED: begin
                if (w_release) begin
                    w_arb = 1'b1;
                    if (w_any) begin
                        w_nxt_state = LOCKED;
                        w_nxt_grant = w_pick;
                        w_nxt_ptr   = w_pick_idx;
                    end else begin
                        w_nxt_state = IDLE;
                        w_nxt_grant = {N{1'b0}};
                    end
                end else begin
                    w_nxt_state = LOCKED;
                end
            end
            default: begin
                w_nxt_state = IDLE;
                w_nxt_grant = {N{1'b0}};
                w_nxt_ptr   = IW'(N - 1);
            end
        endcase
    end

    // State, pointer and registered grant outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_ptr       <= IW'(N - 1);
            r_grant     <= {N{1'b0}};
            r_grant_idx <= {IW{1'b0}};
            r_grant_vld <= 1'b0;
        end else begin
            r_state     <= w_nxt_state;
            r_ptr       <= w_nxt_ptr;
            r_grant     <= w_nxt_grant;
            r_grant_idx <= IW'(onehot2bin(ARB_MAX_N'(w_nxt_grant)));
            r_grant_vld <= |w_nxt_grant;
        end
    end

    assign grant     = r_grant;
    assign grant_idx = r_grant_idx;
    assign grant_vld = r_grant_vld;

endmodule

// File: tb/tb_rr_arbiter_lock.sv
module tb_rr_arbiter_lock;

    localparam int N  = 4;
    localparam int MB = 4;
`ifdef ARB_BURST_LIMIT_EN
    localparam bit BURST_EN = 1'b1;
`else
    localparam bit BURST_EN = 1'b0;
`endif

    logic       clk;
    logic       rst;
    logic [3:0] req;
    logic       ack;
    logic       last;
    logic [3:0] grant;
    logic [1:0] grant_idx;
    logic       grant_vld;

    rr_arbiter_lock #(
        .N         (N),
        .MAX_BURST (MB)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .ack       (ack),
        .last      (last),
        .grant     (grant),
        .grant_idx (grant_idx),
        .grant_vld (grant_vld)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0] g;
        logic [1:0] i;
        logic       v;
    } exp_t;

    exp_t q[$];
    exp_t e;
    int   n_checks = 0;
    int   n_pass   = 0;

    // reference model state
    bit m_locked;
    int m_owner;
    int m_ptr;
    int m_cnt;

    function automatic int search(input logic [3:0] rq, input int p);
        for (int k = 1; k <= N; k++) begin
            if (rq[(p + k) % N]) return (p + k) % N;
        end
        return -1;
    endfunction

    task automatic model_step(input logic r, input logic [3:0] rq, input logic a, input logic l);
        bit rel;
        int w;
        if (r) begin
            m_locked = 1'b0; m_owner = 0; m_ptr = N - 1; m_cnt = 0;
        end else if (!m_locked) begin
            w = search(rq, m_ptr);
            if (w >= 0) begin
                m_locked = 1'b1; m_owner = w; m_ptr = w; m_cnt = 0;
            end
        end else begin
            rel = (a && l) || !rq[m_owner] || (BURST_EN && a && (m_cnt + 1 == MB));
            if (rel) begin
                w = search(rq, m_ptr);
                m_cnt = 0;
                if (w >= 0) begin
                    m_owner = w; m_ptr = w;
                end else begin
                    m_locked = 1'b0;
                end
            end else if (a) begin
                m_cnt = m_cnt + 1;
            end
        end
    endtask

    // drive one cycle, push the model's expectation, then pop it after the edge
    task automatic cycle(input logic r, input logic [3:0] rq, input logic a, input logic l);
        exp_t x;
        rst = r; req = rq; ack = a; last = l;
        model_step(r, rq, a, l);
        x.g = m_locked ? (4'b0001 << m_owner) : 4'b0000;
        x.i = m_locked ? 2'(m_owner) : 2'd0;
        x.v = m_locked;
        q.push_back(x);
        @(posedge clk);
        #1;
        e = q.pop_front();
    endtask

    task automatic test_reset();
        cycle(1'b1, 4'b0000, 1'b0, 1'b0);
        cycle(1'b1, 4'b1111, 1'b1, 1'b1);
        n_checks++;
        if ({grant, grant_idx, grant_vld} !== 7'b0000_00_0) begin
            $display("FAIL reset: got g=%b i=%0d v=%b, want 0000/0/0", grant, grant_idx, grant_vld);
        end else n_pass++;
    endtask

    task automatic test_rotation();
        logic [3:0] seq [5];
        seq[0] = 4'b0001; seq[1] = 4'b0010; seq[2] = 4'b0100; seq[3] = 4'b1000; seq[4] = 4'b0001;
        cycle(1'b1, 4'b0000, 1'b0, 1'b0);
        for (int k = 0; k < 5; k++) begin
            cycle(1'b0, 4'b1111, 1'b1, 1'b1);
            n_checks++;
            if (grant !== seq[k] || {grant, grant_idx, grant_vld} !== e) begin
                $display("FAIL rotation step %0d: got g=%b i=%0d, want g=%b i=%0d", k, grant, grant_idx, seq[k], e.i);
            end else n_pass++;
        end
    endtask

    task automatic test_hold();
        cycle(1'b1, 4'b0000, 1'b0, 1'b0);
        cycle(1'b0, 4'b0101, 1'b0, 1'b0);
        for (int k = 0; k < 5; k++) begin
            cycle(1'b0, 4'b0101, 1'b1, 1'b0);
            n_checks++;
            if ({grant, grant_idx, grant_vld} !== e || (!BURST_EN && grant !== 4'b0001)) begin
                $display("FAIL hold beat %0d: got g=%b, want g=%b", k, grant, e.g);
            end else n_pass++;
        end
        cycle(1'b0, 4'b0101, 1'b1, 1'b1);
        n_checks++;
        if ({grant, grant_idx, grant_vld} !== e) begin
            $display("FAIL hold_release: got g=%b, want g=%b", grant, e.g);
        end else n_pass++;
    endtask

    task automatic test_abort();
        cycle(1'b1, 4'b0000, 1'b0, 1'b0);
        cycle(1'b0, 4'b1100, 1'b0, 1'b0);
        n_checks++;
        if (grant !== 4'b0100 || grant_idx !== 2'd2) begin
            $display("FAIL abort_first: got g=%b i=%0d, want 0100/2", grant, grant_idx);
        end else n_pass++;
        cycle(1'b0, 4'b1000, 1'b0, 1'b0);
        n_checks++;
        if (grant !== 4'b1000 || grant_idx !== 2'd3 || {grant, grant_idx, grant_vld} !== e) begin
            $display("FAIL abort_handover: got g=%b i=%0d, want 1000/3", grant, grant_idx);
        end else n_pass++;
        // ptr is now 3, so requester 0 wins next
        cycle(1'b0, 4'b1111, 1'b1, 1'b1);
        n_checks++;
        if (grant !== 4'b0001) begin
            $display("FAIL abort_ptr: got g=%b, want 0001", grant);
        end else n_pass++;
    endtask

    task automatic test_simul_release();
        cycle(1'b1, 4'b0000, 1'b0, 1'b0);
        cycle(1'b0, 4'b1111, 1'b0, 1'b0);
        cycle(1'b0, 4'b1110, 1'b1, 1'b1);
        n_checks++;
        if (grant !== 4'b0010) begin
            $display("FAIL simul_release1: got g=%b, want 0010", grant);
        end else n_pass++;
        cycle(1'b0, 4'b1101, 1'b1, 1'b1);
        n_checks++;
        if (grant !== 4'b0100 || {grant, grant_idx, grant_vld} !== e) begin
            $display("FAIL simul_release2: got g=%b, want 0100", grant);
        end else n_pass++;
    endtask

    task automatic test_burst();
        logic [3:0] want;
        cycle(1'b1, 4'b0000, 1'b0, 1'b0);
        cycle(1'b0, 4'b0011, 1'b1, 1'b0);
        for (int k = 0; k < 12; k++) begin
            cycle(1'b0, 4'b0011, 1'b1, 1'b0);
            // beats of the current grant start at index 0 after the first grant
            want = (BURST_EN && (((k + 1) / MB) % 2 == 1)) ? 4'b0010 : 4'b0001;
            n_checks++;
            if (grant !== want || {grant, grant_idx, grant_vld} !== e) begin
                $display("FAIL burst cyc %0d: got g=%b, want g=%b", k, grant, want);
            end else n_pass++;
        end
    endtask

    task automatic test_single();
        cycle(1'b1, 4'b0000, 1'b0, 1'b0);
        for (int k = 0; k < 5; k++) begin
            cycle(1'b0, 4'b0100, 1'b1, 1'b1);
            n_checks++;
            if (grant !== 4'b0100 || grant_idx !== 2'd2 || grant_vld !== 1'b1) begin
                $display("FAIL single cyc %0d: got g=%b i=%0d v=%b, want 0100/2/1", k, grant, grant_idx, grant_vld);
            end else n_pass++;
        end
    endtask

    task automatic test_reset_mid();
        cycle(1'b1, 4'b0000, 1'b0, 1'b0);
        cycle(1'b0, 4'b0010, 1'b0, 1'b0);
        cycle(1'b1, 4'b1111, 1'b1, 1'b1);
        n_checks++;
        if (grant !== 4'b0000 || grant_vld !== 1'b0 || grant_idx !== 2'd0) begin
            $display("FAIL reset_mid: got g=%b v=%b, want 0000/0", grant, grant_vld);
        end else n_pass++;
        cycle(1'b0, 4'b1111, 1'b0, 1'b0);
        n_checks++;
        if (grant !== 4'b0001) begin
            $display("FAIL reset_mid_regrant: got g=%b, want 0001", grant);
        end else n_pass++;
    endtask

    task automatic test_random();
        logic [3:0] rq;
        cycle(1'b1, 4'b0000, 1'b0, 1'b0);
        for (int k = 0; k < 300; k++) begin
            rq = 4'($urandom_range(0, 15));
            cycle(($urandom_range(0, 49) == 0) ? 1'b1 : 1'b0, rq,
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            n_checks++;
            if ({grant, grant_idx, grant_vld} !== e || !$onehot0(grant)) begin
                $display("FAIL random cyc %0d: got g=%b i=%0d v=%b, want g=%b i=%0d v=%b",
                         k, grant, grant_idx, grant_vld, e.g, e.i, e.v);
            end else n_pass++;
        end
    endtask

    initial begin
        rst = 1'b1; req = 4'b0000; ack = 1'b0; last = 1'b0;
        m_locked = 1'b0; m_owner = 0; m_ptr = N - 1; m_cnt = 0;
        test_reset();
        test_rotation();
        test_hold();
        test_abort();
        test_simul_release();
        test_burst();
        test_single();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
